// File: rtl/button_pkg.sv
// Shared defaults and sizing helper for the button conditioner.
// Imported by the per-channel debouncer and the top level.
package button_pkg;

   localparam int N_BUTTONS     = 4;
   localparam int DEBOUNCE_10MS = 250000;

   function automatic int cnt_width(input int d);
      return (d < 1) ? 1 : $clog2(d + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce counter,
// debounced level and single-cycle press/release pulses.
module debounce_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE = DEBOUNCE_10MS
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic press_next
);

   localparam int              CW       = cnt_width(DEBOUNCE);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   logic          s1_q;
   logic          s2_q;
   logic          level_q,   level_d;
   logic          press_q,   press_d;
   logic          release_q, release_d;
   logic [CW-1:0] cnt_q,     cnt_d;

   // Count consecutive edges where the synced input disagrees with level.
   always_comb begin
      level_d   = level_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d   = s2_q;
            press_d   = s2_q;
            release_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= raw;
         s2_q      <= s1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         cnt_q     <= cnt_d;
      end
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign press_next    = press_d;

endmodule

// File: rtl/button_conditioner.sv
// N independent debounced button channels plus a registered
// any_press flag aligned with the per-channel press pulses.
module button_conditioner
   import button_pkg::*;
#(
   parameter int N        = N_BUTTONS,
   parameter int DEBOUNCE = DEBOUNCE_10MS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] raw,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   // "release" is a reserved word, hence the suffix
   output logic [N-1:0] release_pulse,
   output logic         any_press
);

   logic [N-1:0] press_next;
   logic         any_press_q, any_press_d;

   for (genvar i = 0; i < N; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE (DEBOUNCE)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .raw           (raw[i]),
         .level         (level[i]),
         .press         (press[i]),
         .release_pulse (release_pulse[i]),
         .press_next    (press_next[i])
      );
   end

   always_comb begin
      any_press_d = |press_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         any_press_q <= 1'b0;
      end else begin
         any_press_q <= any_press_d;
      end
   end

   assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench: eight conditioners (DEBOUNCE=1..8) on one raw bus, checked
// against a sliding-window model of raw samples taken at each edge.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] raw;

   logic [3:0] lvl  [1:8];
   logic [3:0] prs  [1:8];
   logic [3:0] rls  [1:8];
   logic       anyp [1:8];

   always #5 clk = ~clk;

   for (genvar g = 1; g <= 8; g++) begin : g_dut
      button_conditioner #(
         .N        (4),
         .DEBOUNCE (g)
      ) dut (
         .clk           (clk),
         .reset         (reset),
         .raw           (raw),
         .level         (lvl[g]),
         .press         (prs[g]),
         .release_pulse (rls[g]),
         .any_press     (anyp[g])
      );
   end

   // hist[j] = raw as seen at the edge j edges ago (0 = latest)
   logic [3:0] hist  [0:9];
   logic [3:0] m_lvl [1:8];
   logic [3:0] m_prs [1:8];
   logic [3:0] m_rls [1:8];
   int pass_cnt = 0;
   int total    = 0;
   int runlen [0:3];

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%b expected=%b t=%0t",
                  tag, obs, exp, $time);
   endtask

   task automatic model_clear();
      for (int j = 0; j < 10; j++) hist[j] = '0;
      for (int d = 1; d <= 8; d++) begin
         m_lvl[d] = '0;
         m_prs[d] = '0;
         m_rls[d] = '0;
      end
   endtask

   // A change is accepted once the raw value sampled over the d edges
   // that feed the synchronized copy has been opposite to level throughout.
   task automatic model_edge();
      bit ok;
      if (reset) begin
         model_clear();
         return;
      end
      for (int j = 9; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = raw;
      for (int d = 1; d <= 8; d++) begin
         m_prs[d] = '0;
         m_rls[d] = '0;
         for (int c = 0; c < 4; c++) begin
            ok = 1'b1;
            for (int j = 2; j <= d + 1; j++)
               if (hist[j][c] == m_lvl[d][c]) ok = 1'b0;
            if (ok) begin
               m_lvl[d][c] = ~m_lvl[d][c];
               if (m_lvl[d][c]) m_prs[d][c] = 1'b1;
               else             m_rls[d][c] = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int d = 1; d <= 8; d++) begin
         chk($sformatf("level_d%0d", d), lvl[d], m_lvl[d]);
         chk($sformatf("press_d%0d", d), prs[d], m_prs[d]);
         chk($sformatf("release_d%0d", d), rls[d], m_rls[d]);
         chk($sformatf("any_press_d%0d", d), {3'b0, anyp[d]},
             {3'b0, |m_prs[d]});
         chk($sformatf("excl_d%0d", d), prs[d] & rls[d], 4'b0);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      reset = 1'b1;
      raw   = '0;
      #1;
      model_clear();
      check_all();
      step(2);
      reset = 1'b0;
      step(3);

      // single press on channel 0
      raw[0] = 1'b1;
      step(5);
      chk("r25_pre_level", lvl[4], 4'b0000);
      step(1);
      chk("r25_level", lvl[4], 4'b0001);
      chk("r25_press", prs[4], 4'b0001);
      chk("r25_any", {3'b0, anyp[4]}, 4'b0001);
      step(1);
      chk("r25_press_gone", prs[4], 4'b0000);
      chk("r25_any_gone", {3'b0, anyp[4]}, 4'b0000);
      raw[0] = 1'b0;
      step(12);
      chk("r25_released", lvl[4], 4'b0000);

      // 3-cycle glitch on channel 1 is rejected
      raw[1] = 1'b1;
      step(3);
      raw[1] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk("r26_quiet", {lvl[4][1], prs[4][1], rls[4][1], 1'b0}, 4'b0);
      end

      // bouncing channel 2 gives a single press
      begin
         logic [4:0] bnc;
         bnc = 5'b10110;
         for (int k = 4; k >= 0; k--) begin
            raw[2] = bnc[k];
            step(1);
            chk("r27_bounce", {3'b0, prs[4][2]}, 4'b0);
         end
      end
      raw[2] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk("r27_wait", {3'b0, prs[4][2]}, 4'b0);
      end
      step(1);
      chk("r27_press", prs[4], 4'b0100);
      step(1);
      chk("r27_once", prs[4], 4'b0000);
      raw = '0;
      step(12);

      // all channels together
      raw = 4'b1111;
      step(5);
      chk("r28_no_early", prs[4], 4'b0000);
      step(1);
      chk("r28_press_all", prs[4], 4'b1111);
      step(1);
      chk("r28_press_once", prs[4], 4'b0000);
      raw = 4'b0000;
      step(5);
      step(1);
      chk("r28_release_all", rls[4], 4'b1111);
      step(1);
      chk("r28_release_once", rls[4], 4'b0000);
      step(6);

      // reset in the middle of a count on channel 3
      raw[3] = 1'b1;
      step(4);
      reset = 1'b1;
      #1;
      model_clear();
      check_all();
      chk("r29_level_rst", lvl[4], 4'b0000);
      step(2);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk("r29_wait", prs[4], 4'b0000);
      end
      step(1);
      chk("r29_press", prs[4], 4'b1000);
      chk("r29_level", lvl[4], 4'b1000);
      raw = '0;
      step(12);

      // randomized runs with occasional reset
      for (int c = 0; c < 4; c++) runlen[c] = $urandom_range(1, 12);
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int c = 0; c < 4; c++) begin
            runlen[c]--;
            if (runlen[c] <= 0) begin
               raw[c]    = ~raw[c];
               runlen[c] = $urandom_range(1, 12);
            end
         end
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            #1;
            model_clear();
            check_all();
            step(1);
            reset = 1'b0;
         end
         step(1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
